adap_quan_mc: RTL and testbench
===============================

Name: adap_quan_mc

Overview:
- Pipelined, time-multiplexed G.726 adaptive quantizer serving NCH channels. Each channel has its own rate.
- Per sample: log conversion of D, subtraction of the scale factor Y, then rate-dependent quantization to code I.
- Sits between the difference-signal generator and the quantizer scale factor adaptation / inverse quantizer path of the multi-channel encoder.
- Adds valid/ready flow control, a per-channel rate register file and a channel tag passthrough.

Parameters:
- NCH, 32, number of channels.
- CHW, 5, channel index width; must satisfy 2**CHW >= NCH.
- RATE_DEFAULT, 2'd1, reset value of every channel rate; also the rate used for out-of-range channels.

Ports:
- CLK  input  1  clock, rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  sample present.
- IN_READY  output  1  block accepts the sample this cycle.
- IN_CH  input  CHW  channel of the sample.
- D  input  16  difference signal, two's complement.
- Y  input  13  quantizer scale factor, unsigned.
- CFG_WE  input  1  write the per-channel rate.
- CFG_CH  input  CHW  channel being configured.
- CFG_RATE  input  2  rate code: 0=40, 1=32, 2=24, 3=16 kbit/s.
- OUT_VALID  output  1  result present.
- OUT_READY  input  1  downstream accepts the result.
- OUT_CH  output  CHW  channel tag of the result.
- OUT_RATE  output  2  rate used to produce I.
- I  output  5  ADPCM code, LSB-aligned; unused upper bits are 0.

Behaviour:
- Reset (async assert, sync release):
  - All stage valids are 0, so OUT_VALID=0.
  - OUT_CH=0, OUT_RATE=0, I=0.
  - All rate registers = RATE_DEFAULT.
- Pipeline: three register stages.
  - S1 captures D, Y, IN_CH and the channel rate.
  - S2 holds DL, DS, Y, tag and rate.
  - S3 is the output register holding I, tag and rate.
  - A sample accepted at edge t is presented after edge t+2 when there is no stall. Throughput is 1 sample/clock.
- Handshake:
  - A transfer occurs when VALID&READY is high at the edge.
  - Stage k advances when it is empty or stage k+1 advances. S3 advances when OUT_READY=1 or S3 is empty.
  - IN_READY = !S1valid | S1advances. The combinational path from OUT_READY to IN_READY is permitted.
  - While OUT_VALID=1 and OUT_READY=0, S3 and its outputs hold stable. No sample is dropped or duplicated.
  - Bubbles collapse.
- LOG stage:
  - DS = D[15].
  - DQM = DS ? ((-D) & 0x7FFF) : D[14:0]. Note D=0x8000 gives DQM=0.
  - EXP = floor(log2 DQM), with EXP=0 when DQM=0.
  - MANT = ((DQM<<7)>>EXP) & 0x7F.
  - DL = EXP*128 + MANT, 11 bits unsigned.
- SUBTB stage:
  - DLN = DL - (Y>>2), 12-bit two's complement; no saturation is needed.
- QUAN stage: |I| = number of threshold entries T with DLN >= T, comparison signed. Tables per rate:
  - 40k: -122, -16, 68, 139, 198, 250, 298, 339, 378, 413, 445, 475, 502, 528, 553. N=15, 5-bit code.
  - 32k: -124, 80, 178, 246, 300, 349, 400. N=7, 4-bit code.
  - 24k: 8, 218, 331. N=3, 3-bit code.
  - 16k: 261. N=1, 2-bit code.
- Code mapping, rates 40/32/24:
  - DS=1: I = 2N+1 - |I|.
  - DS=0 and |I|=0: I = 2N+1.
  - Otherwise I = |I|.
- Code mapping, rate 16:
  - DS=0: I = |I|.
  - DS=1: I = 3 - |I|.
- Rate registers:
  - A CFG_WE write takes effect at the edge.
  - A sample accepted at that same edge for the same channel uses the old rate. Later samples use the new rate.
  - Samples already in flight keep their captured rate.
  - A CFG_CH >= NCH write is ignored.
  - IN_CH >= NCH is processed with RATE_DEFAULT, and OUT_CH echoes IN_CH.
- Reset mid-operation flushes all in-flight samples, and rates return to RATE_DEFAULT.

Test Plan:
- 32k, D=0x0100, Y=544 → DL=1024, DLN=888, I=7. Same with D=0xFF00 → I=8. D=0, Y=544 → DLN=-136, I=15.
- 40k, D=0x0100, Y=4096 → DLN=0, I=2. With D=0xFF00 → I=29. 24k, same inputs → I=7 (positive zero). 16k → I=0; with D=0xFF00 → I=3.
- D=0x8000, 32k, Y=0 → DQM=0, DLN=0, I=14. D=0x7FFF, Y=0 → DL=1919, I=7.
- Stream 64 samples across 4 channels with random OUT_READY (50%) → outputs in order, correct OUT_CH/I, no loss or duplication. With OUT_READY=1 the first result appears 2 edges after acceptance at 1/clock.
- Write CFG channel 3 rate=0 at the same edge a channel-3 sample is accepted → that sample uses the old rate. The next channel-3 sample uses 40k, with OUT_RATE=0.
- Assert RESET_N low with 3 samples in flight → OUT_VALID=0 immediately; after release no stale outputs and all rates = RATE_DEFAULT.

Source files
------------

// File: rtl/adap_quan_mc.sv
// ============================================================================
// Module   : adap_quan_mc
// Brief    : Three-stage, time-multiplexed adaptive quantizer (log, subtract
//            scale factor, rate-dependent threshold search) with valid/ready
//            flow control and a per-channel rate register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adap_quan_mc #(
    parameter int          NCH          = 32,
    parameter int          CHW          = 5,
    parameter logic [1:0]  RATE_DEFAULT = 2'd1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [CHW-1:0]  IN_CH,
    input  logic [15:0]     D,
    input  logic [12:0]     Y,
    input  logic            CFG_WE,
    input  logic [CHW-1:0]  CFG_CH,
    input  logic [1:0]      CFG_RATE,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [CHW-1:0]  OUT_CH,
    output logic [1:0]      OUT_RATE,
    output logic [4:0]      I
);

    localparam logic signed [11:0] c_thr_40 [15] = '{
        -12'sd122, -12'sd16, 12'sd68, 12'sd139, 12'sd198, 12'sd250, 12'sd298,
        12'sd339, 12'sd378, 12'sd413, 12'sd445, 12'sd475, 12'sd502, 12'sd528,
        12'sd553};
    localparam logic signed [11:0] c_thr_32 [7] = '{
        -12'sd124, 12'sd80, 12'sd178, 12'sd246, 12'sd300, 12'sd349, 12'sd400};
    localparam logic signed [11:0] c_thr_24 [3] = '{12'sd8, 12'sd218, 12'sd331};
    localparam logic signed [11:0] c_thr_16     = 12'sd261;

    // ------------------------------------------------------------------
    // Per-channel rate register file
    // ------------------------------------------------------------------
    logic [1:0]  r_rate [NCH];
    logic [31:0] w_cfg_ch32;
    logic [31:0] w_in_ch32;
    logic [1:0]  w_in_rate;

    assign w_cfg_ch32 = {{(32-CHW){1'b0}}, CFG_CH};
    assign w_in_ch32  = {{(32-CHW){1'b0}}, IN_CH};

    // Writes to channels without a register simply match no generate slot.
    for (genvar g = 0; g < NCH; g++) begin : g_rate
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_rate[g] <= RATE_DEFAULT;
            end else if (CFG_WE && (w_cfg_ch32 == g)) begin
                r_rate[g] <= CFG_RATE;
            end
        end
    end

    always_comb begin
        w_in_rate = RATE_DEFAULT;
        for (int k = 0; k < NCH; k++) begin
            if (w_in_ch32 == k) begin
                w_in_rate = r_rate[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake: each stage advances when empty or its successor advances
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic r_v3;
    logic w_adv1;
    logic w_adv2;
    logic w_adv3;

    assign w_adv3   = !r_v3 || OUT_READY;
    assign w_adv2   = !r_v2 || w_adv3;
    assign w_adv1   = !r_v1 || w_adv2;
    assign IN_READY = w_adv1;

    // ------------------------------------------------------------------
    // Stage 1: capture sample, tag and rate
    // ------------------------------------------------------------------
    logic [15:0]    r_d1;
    logic [12:0]    r_y1;
    logic [CHW-1:0] r_ch1;
    logic [1:0]     r_rate1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_v1    <= 1'b0;
            r_d1    <= '0;
            r_y1    <= '0;
            r_ch1   <= '0;
            r_rate1 <= '0;
        end else if (w_adv1) begin
            r_v1 <= IN_VALID;
            if (IN_VALID) begin
                r_d1    <= D;
                r_y1    <= Y;
                r_ch1   <= IN_CH;
                r_rate1 <= w_in_rate;
            end
        end
    end

    // ------------------------------------------------------------------
    // LOG: magnitude, exponent (MSB position) and 7-bit mantissa
    // ------------------------------------------------------------------
    logic        w_ds;
    logic [15:0] w_neg;
    logic [14:0] w_dqm;
    logic [3:0]  w_exp;
    logic [21:0] w_shift;
    logic [10:0] w_dl;

    assign w_ds    = r_d1[15];
    assign w_neg   = 16'd0 - r_d1;
    assign w_dqm   = w_ds ? w_neg[14:0] : r_d1[14:0];
    assign w_shift = {w_dqm, 7'd0} >> w_exp;
    assign w_dl    = {w_exp, w_shift[6:0]};

    always_comb begin
        w_exp = 4'd0;
        for (int k = 1; k < 15; k++) begin
            if (w_dqm[k]) begin
                w_exp = 4'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: log-domain value and sign
    // ------------------------------------------------------------------
    logic [10:0]    r_dl2;
    logic           r_ds2;
    logic [12:0]    r_y2;
    logic [CHW-1:0] r_ch2;
    logic [1:0]     r_rate2;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_v2    <= 1'b0;
            r_dl2   <= '0;
            r_ds2   <= 1'b0;
            r_y2    <= '0;
            r_ch2   <= '0;
            r_rate2 <= '0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_dl2   <= w_dl;
                r_ds2   <= w_ds;
                r_y2    <= r_y1;
                r_ch2   <= r_ch1;
                r_rate2 <= r_rate1;
            end
        end
    end

    // ------------------------------------------------------------------
    // SUBTB and QUAN: both operands are at most 11 bits, so 12 bits never wrap
    // ------------------------------------------------------------------
    logic signed [11:0] w_dln;
    logic [3:0]         w_mag;
    logic [4:0]         w_code;

    assign w_dln = $signed({1'b0, r_dl2} - {1'b0, r_y2[12:2]});

    always_comb begin
        w_mag = 4'd0;
        case (r_rate2)
            2'd0: begin
                for (int k = 0; k < 15; k++) begin
                    if (w_dln >= c_thr_40[k]) w_mag = w_mag + 4'd1;
                end
            end
            2'd1: begin
                for (int k = 0; k < 7; k++) begin
                    if (w_dln >= c_thr_32[k]) w_mag = w_mag + 4'd1;
                end
            end
            2'd2: begin
                for (int k = 0; k < 3; k++) begin
                    if (w_dln >= c_thr_24[k]) w_mag = w_mag + 4'd1;
                end
            end
            default: begin
                if (w_dln >= c_thr_16) w_mag = 4'd1;
            end
        endcase
    end

    // Negative and positive-zero magnitudes fold onto the upper half of the code space
    always_comb begin
        w_code = 5'd0;
        case (r_rate2)
            2'd0: w_code = r_ds2 ? (5'd31 - {1'b0, w_mag})
                                 : ((w_mag == 4'd0) ? 5'd31 : {1'b0, w_mag});
            2'd1: w_code = r_ds2 ? (5'd15 - {1'b0, w_mag})
                                 : ((w_mag == 4'd0) ? 5'd15 : {1'b0, w_mag});
            2'd2: w_code = r_ds2 ? (5'd7 - {1'b0, w_mag})
                                 : ((w_mag == 4'd0) ? 5'd7 : {1'b0, w_mag});
            default: w_code = r_ds2 ? (5'd3 - {1'b0, w_mag}) : {1'b0, w_mag};
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 3: output register
    // ------------------------------------------------------------------
    logic [4:0]     r_i3;
    logic [CHW-1:0] r_ch3;
    logic [1:0]     r_rate3;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_v3    <= 1'b0;
            r_i3    <= '0;
            r_ch3   <= '0;
            r_rate3 <= '0;
        end else if (w_adv3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_i3    <= w_code;
                r_ch3   <= r_ch2;
                r_rate3 <= r_rate2;
            end
        end
    end

    assign OUT_VALID = r_v3;
    assign OUT_CH    = r_ch3;
    assign OUT_RATE  = r_rate3;
    assign I         = r_i3;

endmodule

`default_nettype wire

// File: tb/tb_adap_quan_mc.sv
// ============================================================================
// Module   : tb_adap_quan_mc
// Brief    : Self-checking bench for adap_quan_mc against a scoreboard model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adap_quan_mc;

    localparam int NCH = 24;
    localparam int CHW = 5;

    logic           CLK;
    logic           RESET_N;
    logic           IN_VALID;
    logic           IN_READY;
    logic [CHW-1:0] IN_CH;
    logic [15:0]    D;
    logic [12:0]    Y;
    logic           CFG_WE;
    logic [CHW-1:0] CFG_CH;
    logic [1:0]     CFG_RATE;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [CHW-1:0] OUT_CH;
    logic [1:0]     OUT_RATE;
    logic [4:0]     out_i;

    adap_quan_mc #(.NCH(NCH), .CHW(CHW), .RATE_DEFAULT(2'd1)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_CH(IN_CH), .D(D), .Y(Y),
        .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_RATE(CFG_RATE),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CH(OUT_CH),
        .OUT_RATE(OUT_RATE), .I(out_i)
    );

    typedef struct {
        int ch;
        int rate;
        int code;
        int spec;
        int acc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   mrate [NCH];
    int   cyc = 0;
    int   cur_spec = -1;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
    bit   lat_mode = 0;
    int   last_pop = -1;

    int t40 [15] = '{-122, -16, 68, 139, 198, 250, 298, 339, 378, 413, 445, 475, 502, 528, 553};
    int t32 [7]  = '{-124, 80, 178, 246, 300, 349, 400};
    int t24 [3]  = '{8, 218, 331};

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_code(input int d, input int y, input int rate);
        int ds, dqm, e, dl, dln, mag, n, top, t;
        ds  = (d >> 15) & 1;
        dqm = ds ? ((-d) & 'h7FFF) : (d & 'h7FFF);
        e = 0;
        while ((dqm >> (e + 1)) != 0) e++;
        dl  = e * 128 + (((dqm << 7) >> e) & 'h7F);
        dln = dl - (y >> 2);
        n   = (rate == 0) ? 15 : (rate == 1) ? 7 : (rate == 2) ? 3 : 1;
        mag = 0;
        for (int k = 0; k < n; k++) begin
            t = (rate == 0) ? t40[k] : (rate == 1) ? t32[k] : (rate == 2) ? t24[k] : 261;
            if (dln >= t) mag++;
        end
        if (rate == 3) return ds ? 3 - mag : mag;
        top = 2 * n + 1;
        if (ds != 0) return top - mag;
        if (mag == 0) return top;
        return mag;
    endfunction

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        OUT_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            OUT_READY = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom % 2);
        end
    end

    // Scoreboard: everything is sampled at the falling edge, between driver updates
    initial begin : monitor
        exp_t e;
        bit   held;
        int   held_i, held_ch;
        held = 0;
        held_i = 0;
        held_ch = 0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                q.delete();
                for (int k = 0; k < NCH; k++) mrate[k] = 1;
                held = 0;
                last_pop = -1;
            end else begin
                cyc++;
                if (IN_VALID && IN_READY) begin
                    e.ch   = int'(IN_CH);
                    e.rate = (int'(IN_CH) < NCH) ? mrate[IN_CH] : 1;
                    e.code = ref_code(int'(D), int'(Y), e.rate);
                    e.spec = cur_spec;
                    e.acc  = cyc;
                    q.push_back(e);
                end
                if (CFG_WE && int'(CFG_CH) < NCH) mrate[CFG_CH] = int'(CFG_RATE);
                if (held) begin
                    chk("hold_valid", int'(OUT_VALID), 1);
                    chk("hold_i", int'(out_i), held_i);
                    chk("hold_ch", int'(OUT_CH), held_ch);
                end
                held    = OUT_VALID && !OUT_READY;
                held_i  = int'(out_i);
                held_ch = int'(OUT_CH);
                if (OUT_VALID && OUT_READY) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("out_ch", int'(OUT_CH), e.ch);
                        chk("out_rate", int'(OUT_RATE), e.rate);
                        chk("out_i", int'(out_i), e.code);
                        if (e.spec >= 0) chk("spec_i", int'(out_i), e.spec);
                        // acceptance falls-edge c -> result seen on falling edge c+3
                        if (lat_mode) begin
                            chk("latency", cyc - e.acc, 3);
                            if (last_pop >= 0) chk("throughput", cyc - last_pop, 1);
                            last_pop = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int ch, input int d, input int y, input int spec,
                        input bit cfg, input int cch, input int crate);
        int n;
        IN_VALID = 1'b1;
        IN_CH    = ch[CHW-1:0];
        D        = d[15:0];
        Y        = y[12:0];
        cur_spec = spec;
        CFG_WE   = cfg;
        CFG_CH   = cch[CHW-1:0];
        CFG_RATE = crate[1:0];
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!IN_READY && n < 200);
        if (!IN_READY) chk("in_ready_timeout", 0, 1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        CFG_WE   = 1'b0;
        cur_spec = -1;
    endtask

    task automatic cfg_write(input int cch, input int crate);
        CFG_WE   = 1'b1;
        CFG_CH   = cch[CHW-1:0];
        CFG_RATE = crate[1:0];
        @(posedge CLK);
        #1;
        CFG_WE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge CLK);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        #1;
    endtask

    initial begin : main
        RESET_N  = 1'b0;
        IN_VALID = 1'b0;
        IN_CH    = '0;
        D        = '0;
        Y        = '0;
        CFG_WE   = 1'b0;
        CFG_CH   = '0;
        CFG_RATE = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", int'(OUT_VALID), 0);
        chk("rst_out_ch", int'(OUT_CH), 0);
        chk("rst_out_rate", int'(OUT_RATE), 0);
        chk("rst_i", int'(out_i), 0);
        chk("rst_in_ready", int'(IN_READY), 1);
        RESET_N = 1'b1;
        idle(2);

        cfg_write(5, 0);
        cfg_write(6, 2);
        cfg_write(7, 3);
        cfg_write(28, 3);
        idle(2);

        lat_mode = 1;
        send(0, 'h0100, 544, 7, 0, 0, 0);
        send(0, 'hFF00, 544, 8, 0, 0, 0);
        send(0, 'h0000, 544, 15, 0, 0, 0);
        send(5, 'h0100, 4096, 2, 0, 0, 0);
        send(5, 'hFF00, 4096, 29, 0, 0, 0);
        send(6, 'h0100, 4096, 7, 0, 0, 0);
        send(7, 'h0100, 4096, 0, 0, 0, 0);
        send(7, 'hFF00, 4096, 3, 0, 0, 0);
        send(0, 'h8000, 0, 14, 0, 0, 0);
        send(0, 'h7FFF, 0, 7, 0, 0, 0);
        send(28, 'h0100, 544, 7, 0, 0, 0);
        send(30, 'hFF00, 544, 8, 0, 0, 0);
        drain();
        lat_mode = 0;

        // Rate change landing on the same edge as a same-channel sample
        send(3, 'h0100, 544, 7, 1, 3, 0);
        send(3, 'h0100, 544, 15, 0, 0, 0);
        drain();

        rdy_mode = 1;
        for (int s = 0; s < 64; s++) begin
            int ch;
            bit cw;
            ch = ($urandom % 8 == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 3));
            cw = ($urandom % 6 == 0);
            send(ch, int'($urandom % 65536), int'($urandom % 8192), -1,
                 cw, int'($urandom % 32), int'($urandom % 4));
            if ($urandom % 5 == 0) idle(int'($urandom_range(1, 3)));
        end
        drain();

        // Reset with three samples parked in the pipeline
        rdy_mode = 2;
        idle(2);
        cfg_write(3, 0);
        send(1, 'h1234, 100, -1, 0, 0, 0);
        send(2, 'h4321, 200, -1, 0, 0, 0);
        send(3, 'hF00F, 300, -1, 0, 0, 0);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_out_valid", int'(OUT_VALID), 0);
        chk("arst_i", int'(out_i), 0);
        chk("arst_out_ch", int'(OUT_CH), 0);
        chk("arst_out_rate", int'(OUT_RATE), 0);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        rdy_mode = 0;
        idle(6);
        chk("post_rst_no_stale", int'(OUT_VALID), 0);
        send(3, 'h0100, 544, 7, 0, 0, 0);
        send(5, 'h0100, 4096, 1, 0, 0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
